// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the instruction-fetch
// requester (i_*) and the load/store requester (d_*).
//
// A request is accepted in IDLE, strobed to memory for one cycle in ISSUE,
// waits MEM_LAT cycles for read data in WAIT, and completes with a one-cycle
// ready pulse in RESP. Every output is a register, so gnt_i/gnt_d can drive
// the downstream steering mux select without any combinational path from the
// request inputs.
//
// Build option: define ARB_FIXED_PRIO_EN so that a tie always goes to the data
// side. Without it, a tie goes to the side that was not served last
// (round-robin). Timing and handshake are the same in both builds.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; arbitrate and latch the winning request
// ISSUE | mem_en strobe with the latched address/data/we; load counter
// WAIT  | count down the read latency; capture mem_rdata on the last one
// RESP  | one-cycle ready to the winner; remember the winner for fairness

module mem_port_arbiter #(
    parameter int N       = 32,
    parameter int MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         i_req,
    input  logic [N-1:0] i_addr,
    output logic [N-1:0] i_rdata,
    output logic         i_ready,

    input  logic         d_req,
    input  logic         d_we,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic [N-1:0] d_rdata,
    output logic         d_ready,

    output logic         mem_en,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,

    output logic         gnt_i,
    output logic         gnt_d
);

    // MEM_LAT = 1 still needs a one-bit counter.
    localparam int            CW       = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_gnt;   // 1: data side was served last
    logic          lat_we;     // winner's we, kept past ISSUE to gate the rdata capture
    logic          pick_d;     // 1: data side wins the current arbitration

    // Winner for the IDLE cycle; only used when at least one request is high.
    always_comb begin
        pick_d = 1'b0;
        if (d_req && !i_req) begin
            pick_d = 1'b1;
        end else if (d_req && i_req) begin
`ifdef ARB_FIXED_PRIO_EN
            pick_d = 1'b1;
`else
            pick_d = ~last_gnt;
`endif
        end
    end

    // Access sequencer: latches the winner, strobes memory, times the read
    // latency and returns data with a ready pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_gnt  <= 1'b1;
            lat_we    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            gnt_i     <= 1'b0;
            gnt_d     <= 1'b0;
        end else begin
            // Strobe and ready are single-cycle; memory-side fields are zero
            // whenever mem_en is low.
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;

            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        // The mem_* registers are the latched request; they are
                        // presented during ISSUE and cleared afterwards.
                        mem_en    <= 1'b1;
                        gnt_i     <= ~pick_d;
                        gnt_d     <= pick_d;
                        lat_we    <= pick_d & d_we;
                        mem_we    <= pick_d & d_we;
                        mem_addr  <= pick_d ? d_addr : i_addr;
                        mem_wdata <= pick_d ? d_wdata : '0;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= WAIT;
                end

                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        if (gnt_i) begin
                            i_rdata <= mem_rdata;
                        end else if (!lat_we) begin
                            d_rdata <= mem_rdata;
                        end
                        i_ready <= gnt_i;
                        d_ready <= gnt_d;
                        cnt     <= '0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - CNT_LAST;
                    end
                end

                RESP: begin
                    last_gnt <= gnt_d;
                    gnt_i    <= 1'b0;
                    gnt_d    <= 1'b0;
                    lat_we   <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    gnt_i <= 1'b0;
                    gnt_d <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// The reference model works at transaction level: when a request is accepted
// it records the accept cycle and the winner, and every expected output is
// derived from the cycle offset since acceptance. A small memory model answers
// mem_en strobes with data valid exactly MEM_LAT cycles later (random filler
// in all other cycles).

module tb_mem_port_arbiter;

    localparam int N  = 32;
    localparam int ML = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req, d_req, d_we;
    logic [N-1:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [N-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic         i_ready, d_ready, mem_en, mem_we, gnt_i, gnt_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .MEM_LAT(ML)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .gnt_i     (gnt_i),
        .gnt_d     (gnt_d)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // transaction model
    bit           m_busy;
    int           m_r;
    bit           m_win_d;
    bit           m_we;
    bit           m_last_d;
    logic [N-1:0] m_addr, m_wdata;
    logic [N-1:0] exp_i_rdata, exp_d_rdata;

    // memory model
    logic [N-1:0] mem [logic [N-1:0]];
    bit           rd_pend;
    int           rd_due;
    logic [N-1:0] rd_addr;

    // observed ready pulses
    int rq_cyc[$];
    int rq_side[$];

    function automatic logic [N-1:0] mem_rd(input logic [N-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chkw(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy      = 1'b0;
        m_last_d    = 1'b1;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        rd_pend     = 1'b0;
    endtask

    task automatic check_outputs();
        logic         e_en, e_we, e_gi, e_gd, e_ir, e_dr;
        logic [N-1:0] e_addr, e_wdata;
        int           off;
        e_en = 0; e_we = 0; e_gi = 0; e_gd = 0; e_ir = 0; e_dr = 0;
        e_addr = '0; e_wdata = '0;
        if (m_busy) begin
            off  = cyc - m_r;
            e_gi = !m_win_d;
            e_gd = m_win_d;
            if (off == 1) begin
                e_en    = 1'b1;
                e_we    = m_we;
                e_addr  = m_addr;
                e_wdata = m_wdata;
            end
            if (off == ML + 2) begin
                e_ir = !m_win_d;
                e_dr = m_win_d;
                if (!m_win_d)  exp_i_rdata = mem_rd(m_addr);
                else if (!m_we) exp_d_rdata = mem_rd(m_addr);
            end
        end
        chk1("mem_en", mem_en, e_en);
        chk1("mem_we", mem_we, e_we);
        chkw("mem_addr", mem_addr, e_addr);
        if (!e_en || e_we) chkw("mem_wdata", mem_wdata, e_wdata);
        chk1("gnt_i", gnt_i, e_gi);
        chk1("gnt_d", gnt_d, e_gd);
        chk1("gnt_exclusive", gnt_i & gnt_d, 1'b0);
        chk1("i_ready", i_ready, e_ir);
        chk1("d_ready", d_ready, e_dr);
        chkw("i_rdata", i_rdata, exp_i_rdata);
        chkw("d_rdata", d_rdata, exp_d_rdata);
    endtask

    // Advance one cycle, check outputs, then let the memory model react.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (m_busy && (cyc - m_r) == ML + 3) begin
            m_busy   = 1'b0;
            m_last_d = m_win_d;
        end
        check_outputs();
        if (i_ready === 1'b1) begin rq_cyc.push_back(cyc); rq_side.push_back(0); end
        if (d_ready === 1'b1) begin rq_cyc.push_back(cyc); rq_side.push_back(1); end
        if (mem_en === 1'b1 && !reset) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else begin
                rd_pend = 1'b1;
                rd_due  = cyc + ML;
                rd_addr = mem_addr;
            end
        end
        if (rd_pend && cyc == rd_due) begin
            mem_rdata = mem_rd(rd_addr);
            rd_pend   = 1'b0;
        end else begin
            mem_rdata = $urandom;
        end
    endtask

    // Arbitrate the inputs driven for this cycle if the port is free.
    task automatic commit();
        bit pd;
        if (!reset && !m_busy && (i_req || d_req)) begin
            if (i_req && d_req) begin
`ifdef ARB_FIXED_PRIO_EN
                pd = 1'b1;
`else
                pd = !m_last_d;
`endif
            end else begin
                pd = d_req;
            end
            m_busy  = 1'b1;
            m_r     = cyc;
            m_win_d = pd;
            m_we    = pd & d_we;
            m_addr  = pd ? d_addr : i_addr;
            m_wdata = d_wdata;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            commit();
        end
    endtask

    // Assert reset mid-cycle and check outputs clear before any clock edge.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
    endtask

    initial begin
        bit i_hold, d_hold, i_done, d_done;
        int exp_side;

        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        model_reset();
        mem[32'h40] = 32'hDEAD_BEEF;
        run(2);

        // single fetch
        tick(); reset = 1'b0; i_req = 1'b1; i_addr = 32'h40; commit();
        tick(); commit();
        chk1("fetch_issue_en", mem_en, 1'b1);
        chkw("fetch_issue_addr", mem_addr, 32'h40);
        chk1("fetch_issue_gnt_i", gnt_i, 1'b1);
        run(2);
        tick();
        chk1("fetch_ready", i_ready, 1'b1);
        chkw("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
        commit();
        tick(); i_req = 1'b0; commit();
        chk1("fetch_ready_single", i_ready, 1'b0);

        // store
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678; commit();
        tick(); commit();
        chk1("store_issue_we", mem_we, 1'b1);
        chkw("store_issue_wdata", mem_wdata, 32'h1234_5678);
        run(2);
        tick();
        chk1("store_ready", d_ready, 1'b1);
        chkw("store_rdata_kept", d_rdata, 32'h0);
        commit();
        tick(); d_req = 1'b0; d_we = 1'b0; commit();

        // contention from reset
        tick(); async_reset();
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        commit();
        run(2);
        rq_cyc.delete(); rq_side.delete();
        tick(); reset = 1'b0; commit();
        run(4 * (ML + 3) - 2);
        tick(); i_req = 1'b0; d_req = 1'b0; commit();
        chk_int("contention_count", rq_cyc.size(), 4);
        for (int k = 0; k < rq_cyc.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_side = 1;
`else
            exp_side = k % 2;
`endif
            chk_int("contention_order", rq_side[k], exp_side);
            if (k > 0) chk_int("contention_gap", rq_cyc[k] - rq_cyc[k-1], ML + 3);
        end

        // abort in WAIT, then a tie
        tick(); i_req = 1'b1; i_addr = 32'h44; commit();
        run(2);
        rq_cyc.delete(); rq_side.delete();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        async_reset();
        commit();
        run(3);
        chk_int("abort_no_ready", rq_cyc.size(), 0);
        tick(); reset = 1'b0; commit();
        tick(); commit();
`ifdef ARB_FIXED_PRIO_EN
        chk1("abort_tie_gnt_d", gnt_d, 1'b1);
`else
        chk1("abort_tie_gnt_i", gnt_i, 1'b1);
`endif
        run(2);
        tick(); commit();
        chk_int("abort_access_done", rq_cyc.size(), 1);
        tick(); i_req = 1'b0; d_req = 1'b0; commit();

        // randomized traffic
        i_hold = 0; d_hold = 0; i_done = 0; d_done = 0;
        for (int n = 0; n < 600; n++) begin
            tick();
            if (i_done) begin i_done = 0; i_hold = 0; end
            if (d_done) begin d_done = 0; d_hold = 0; end
            if (!i_hold) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 32'($urandom_range(0, 15)) << 2;
                i_hold = i_req;
            end else if (m_busy && !m_win_d) begin
                i_addr = $urandom;
            end
            if (!d_hold) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) != 0;
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
                d_hold  = d_req;
            end else if (m_busy && m_win_d) begin
                d_we    = $urandom_range(0, 1) != 0;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            commit();
            if (i_ready === 1'b1) i_done = 1;
            if (d_ready === 1'b1) d_done = 1;
        end

        tick(); i_req = 1'b0; d_req = 1'b0; commit();
        run(ML + 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
